// File: rtl/gb_cluster_pp.sv
// Global buffer cluster: ping-pong banked iact/wght buffers, an accumulating psum buffer
// and a burst engine that gathers X_dim consecutive psum words for the neighbouring PE.
module gb_cluster_pp #(
    parameter int unsigned DATA_BITWIDTH = 16,
    parameter int unsigned ADDR_BITWIDTH = 10,
    parameter int unsigned X_dim         = 3,
    parameter int unsigned NUM_BANKS     = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    // iact
    input  logic                             read_req_iact,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr_iact,
    output logic [DATA_BITWIDTH-1:0]         r_data_iact,
    output logic                             r_valid_iact,
    input  logic                             write_en_iact,
    input  logic [ADDR_BITWIDTH-1:0]         w_addr_iact,
    input  logic [DATA_BITWIDTH-1:0]         w_data_iact,
    // wght
    input  logic                             read_req_wght,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr_wght,
    output logic [DATA_BITWIDTH-1:0]         r_data_wght,
    output logic                             r_valid_wght,
    input  logic                             write_en_wght,
    input  logic [ADDR_BITWIDTH-1:0]         w_addr_wght,
    input  logic [DATA_BITWIDTH-1:0]         w_data_wght,
    // psum
    input  logic                             read_req_psum,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr_psum,
    output logic [DATA_BITWIDTH-1:0]         r_data_psum,
    output logic                             r_valid_psum,
    input  logic                             write_en_psum,
    input  logic                             acc_en_psum,
    input  logic [ADDR_BITWIDTH-1:0]         w_addr_psum,
    input  logic [DATA_BITWIDTH-1:0]         w_data_psum,
    // inter-PE psum burst
    input  logic                             read_req_psum_inter,
    input  logic [ADDR_BITWIDTH-1:0]         r_addr_psum_inter,
    output logic [DATA_BITWIDTH*X_dim-1:0]   r_data_psum_inter,
    output logic                             read_en_psum_inter,
    output logic                             busy_psum_inter,
    // bank control
    input  logic                             swap,
    output logic [$clog2(NUM_BANKS)-1:0]     wr_bank
);

    localparam int unsigned DEPTH  = 1 << ADDR_BITWIDTH;
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W  = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam int unsigned IW     = DATA_BITWIDTH * X_dim;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(X_dim - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} inter_state_e;

    logic [DATA_BITWIDTH-1:0] iact_mem [NUM_BANKS][DEPTH];
    logic [DATA_BITWIDTH-1:0] wght_mem [NUM_BANKS][DEPTH];
    logic [DATA_BITWIDTH-1:0] psum_mem [DEPTH];

    logic [BANK_W-1:0]        wr_bank_q, rd_bank;
    logic                     psum_wr, psum_acc;
    logic                     rmw_vld_q;
    logic [ADDR_BITWIDTH-1:0] rmw_addr_q;
    logic [DATA_BITWIDTH-1:0] rmw_old_q, rmw_opnd_q, rmw_sum, acc_old;

    inter_state_e             state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] inter_addr_q;
    logic [CNT_W-1:0]         inter_cnt_q;
    logic [IW-1:0]            inter_buf_q, inter_merged;
    logic [DATA_BITWIDTH-1:0] fetch_word;

    // ---------------- bank pointers ----------------
    always_comb rd_bank = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BANK_W'(1);
    assign wr_bank = wr_bank_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    wr_bank_q <= '0;
        else if (swap) wr_bank_q <= rd_bank;
    end

    // ---------------- storage (never reset) ----------------
    always_ff @(posedge clk) begin
        if (write_en_iact) iact_mem[wr_bank_q][w_addr_iact] <= w_data_iact;
        if (write_en_wght) wght_mem[wr_bank_q][w_addr_wght] <= w_data_wght;
    end

    assign psum_wr  = write_en_psum & ~acc_en_psum;
    assign psum_acc = write_en_psum & acc_en_psum;
    assign rmw_sum  = rmw_old_q + rmw_opnd_q;

    // A plain overwrite issued in the commit cycle is younger, so it lands last.
    always_ff @(posedge clk) begin
        if (rmw_vld_q) psum_mem[rmw_addr_q] <= rmw_sum;
        if (psum_wr)   psum_mem[w_addr_psum] <= w_data_psum;
    end

    // Forward a sum that commits on the same edge this accumulate samples its operand.
    always_comb begin
        acc_old = psum_mem[w_addr_psum];
        if (rmw_vld_q && (rmw_addr_q == w_addr_psum)) acc_old = rmw_sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rmw_vld_q  <= 1'b0;
            rmw_addr_q <= '0;
            rmw_old_q  <= '0;
            rmw_opnd_q <= '0;
        end else begin
            rmw_vld_q <= psum_acc;
            if (psum_acc) begin
                rmw_addr_q <= w_addr_psum;
                rmw_old_q  <= acc_old;
                rmw_opnd_q <= w_data_psum;
            end
        end
    end

    // ---------------- regular read ports ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_iact  <= '0;
            r_valid_iact <= 1'b0;
            r_data_wght  <= '0;
            r_valid_wght <= 1'b0;
            r_data_psum  <= '0;
            r_valid_psum <= 1'b0;
        end else begin
            r_valid_iact <= read_req_iact;
            r_valid_wght <= read_req_wght;
            r_valid_psum <= read_req_psum;
            if (read_req_iact) r_data_iact <= iact_mem[rd_bank][r_addr_iact];
            if (read_req_wght) r_data_wght <= wght_mem[rd_bank][r_addr_wght];
            if (read_req_psum) r_data_psum <= psum_mem[r_addr_psum];
        end
    end

    // ---------------- inter-PE burst engine ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (read_req_psum_inter) state_d = StFetch;
            StFetch: if (inter_cnt_q == LAST_CNT) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_psum_inter    = 1'b0;
        read_en_psum_inter = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StFetch: busy_psum_inter = 1'b1;
            StDone: begin
                busy_psum_inter    = 1'b1;
                read_en_psum_inter = 1'b1;
            end
            default: ;
        endcase
    end

    // Each fetch sees any psum write landing on its own sampling edge.
    always_comb begin
        fetch_word = psum_mem[inter_addr_q];
        if (rmw_vld_q && (rmw_addr_q == inter_addr_q))   fetch_word = rmw_sum;
        if (psum_wr && (w_addr_psum == inter_addr_q))    fetch_word = w_data_psum;
    end

    always_comb begin
        inter_merged = inter_buf_q;
        for (int k = 0; k < X_dim; k++) begin
            if (inter_cnt_q == CNT_W'(k)) begin
                inter_merged[k*DATA_BITWIDTH +: DATA_BITWIDTH] = fetch_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inter_addr_q      <= '0;
            inter_cnt_q       <= '0;
            inter_buf_q       <= '0;
            r_data_psum_inter <= '0;
        end else if (state_q == StIdle) begin
            if (read_req_psum_inter) begin
                inter_addr_q <= r_addr_psum_inter;
                inter_cnt_q  <= '0;
            end
        end else if (state_q == StFetch) begin
            inter_addr_q <= inter_addr_q + ADDR_BITWIDTH'(1);
            inter_cnt_q  <= inter_cnt_q + CNT_W'(1);
            inter_buf_q  <= inter_merged;
            if (inter_cnt_q == LAST_CNT) r_data_psum_inter <= inter_merged;
        end
    end

endmodule

// File: tb/tb_gb_cluster_pp.sv
// Directed bench for gb_cluster_pp: bank ping-pong, psum overwrite/accumulate, inter burst,
// asynchronous reset behaviour, and a three-bank instance.
module tb_gb_cluster_pp;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int XD = 3;

    logic clk = 1'b0;
    logic reset;
    logic read_req_iact, write_en_iact, read_req_wght, write_en_wght;
    logic read_req_psum, write_en_psum, acc_en_psum, read_req_psum_inter;
    logic swap, swap3;
    logic [AW-1:0] r_addr_iact, w_addr_iact, r_addr_wght, w_addr_wght;
    logic [AW-1:0] r_addr_psum, w_addr_psum, r_addr_psum_inter;
    logic [DW-1:0] w_data_iact, w_data_wght, w_data_psum;

    logic [DW-1:0]    r_data_iact, r_data_wght, r_data_psum;
    logic             r_valid_iact, r_valid_wght, r_valid_psum;
    logic [DW*XD-1:0] r_data_psum_inter;
    logic             read_en_psum_inter, busy_psum_inter;
    logic [0:0]       wr_bank;

    logic [DW-1:0]    r_data_iact3, r_data_wght3, r_data_psum3;
    logic             r_valid_iact3, r_valid_wght3, r_valid_psum3;
    logic [DW*XD-1:0] r_data_psum_inter3;
    logic             read_en_psum_inter3, busy_psum_inter3;
    logic [1:0]       wr_bank3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gb_cluster_pp #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .NUM_BANKS(2)) u_dut (
        .clk(clk), .reset(reset),
        .read_req_iact(read_req_iact), .r_addr_iact(r_addr_iact), .r_data_iact(r_data_iact),
        .r_valid_iact(r_valid_iact), .write_en_iact(write_en_iact), .w_addr_iact(w_addr_iact),
        .w_data_iact(w_data_iact),
        .read_req_wght(read_req_wght), .r_addr_wght(r_addr_wght), .r_data_wght(r_data_wght),
        .r_valid_wght(r_valid_wght), .write_en_wght(write_en_wght), .w_addr_wght(w_addr_wght),
        .w_data_wght(w_data_wght),
        .read_req_psum(read_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
        .r_valid_psum(r_valid_psum), .write_en_psum(write_en_psum), .acc_en_psum(acc_en_psum),
        .w_addr_psum(w_addr_psum), .w_data_psum(w_data_psum),
        .read_req_psum_inter(read_req_psum_inter), .r_addr_psum_inter(r_addr_psum_inter),
        .r_data_psum_inter(r_data_psum_inter), .read_en_psum_inter(read_en_psum_inter),
        .busy_psum_inter(busy_psum_inter),
        .swap(swap), .wr_bank(wr_bank)
    );

    gb_cluster_pp #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .NUM_BANKS(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .read_req_iact(read_req_iact), .r_addr_iact(r_addr_iact), .r_data_iact(r_data_iact3),
        .r_valid_iact(r_valid_iact3), .write_en_iact(write_en_iact), .w_addr_iact(w_addr_iact),
        .w_data_iact(w_data_iact),
        .read_req_wght(read_req_wght), .r_addr_wght(r_addr_wght), .r_data_wght(r_data_wght3),
        .r_valid_wght(r_valid_wght3), .write_en_wght(write_en_wght), .w_addr_wght(w_addr_wght),
        .w_data_wght(w_data_wght),
        .read_req_psum(read_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum3),
        .r_valid_psum(r_valid_psum3), .write_en_psum(write_en_psum), .acc_en_psum(acc_en_psum),
        .w_addr_psum(w_addr_psum), .w_data_psum(w_data_psum),
        .read_req_psum_inter(read_req_psum_inter), .r_addr_psum_inter(r_addr_psum_inter),
        .r_data_psum_inter(r_data_psum_inter3), .read_en_psum_inter(read_en_psum_inter3),
        .busy_psum_inter(busy_psum_inter3),
        .swap(swap3), .wr_bank(wr_bank3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic iact_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en_iact = 1'b1; w_addr_iact = a; w_data_iact = d;
        step();
        write_en_iact = 1'b0;
    endtask

    task automatic iact_rd(input logic [AW-1:0] a);
        read_req_iact = 1'b1; r_addr_iact = a;
        step();
        read_req_iact = 1'b0;
    endtask

    task automatic psum_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en_psum = 1'b1; acc_en_psum = 1'b0; w_addr_psum = a; w_data_psum = d;
        step();
        write_en_psum = 1'b0;
    endtask

    task automatic psum_rd(input logic [AW-1:0] a);
        read_req_psum = 1'b1; r_addr_psum = a;
        step();
        read_req_psum = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    task automatic do_swap3();
        swap3 = 1'b1;
        step();
        swap3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {read_req_iact, write_en_iact, read_req_wght, write_en_wght} = '0;
        {read_req_psum, write_en_psum, acc_en_psum, read_req_psum_inter, swap, swap3} = '0;
        {r_addr_iact, w_addr_iact, r_addr_wght, w_addr_wght} = '0;
        {r_addr_psum, w_addr_psum, r_addr_psum_inter} = '0;
        {w_data_iact, w_data_wght, w_data_psum} = '0;
        repeat (3) step();

        check("rst_rdata_iact", 64'(r_data_iact), 64'h0);
        check("rst_rvalid_iact", 64'(r_valid_iact), 64'h0);
        check("rst_inter_data", 64'(r_data_psum_inter), 64'h0);
        check("rst_read_en", 64'(read_en_psum_inter), 64'h0);
        check("rst_busy", 64'(busy_psum_inter), 64'h0);
        check("rst_wr_bank", 64'(wr_bank), 64'h0);
        check("rst_wr_bank3", 64'(wr_bank3), 64'h0);
        reset = 1'b1;
        step();

        // iact bank ping-pong
        iact_wr(10'd5, 16'h00AA);
        do_swap();
        check("swap1_wr_bank", 64'(wr_bank), 64'h1);
        iact_rd(10'd5);
        check("iact_rdata", 64'(r_data_iact), 64'h00AA);
        check("iact_rvalid", 64'(r_valid_iact), 64'h1);
        step();
        check("iact_rvalid_drop", 64'(r_valid_iact), 64'h0);
        check("iact_rdata_hold", 64'(r_data_iact), 64'h00AA);

        // wght written into bank 1, read after swapping back
        write_en_wght = 1'b1; w_addr_wght = 10'd9; w_data_wght = 16'h1234;
        step();
        write_en_wght = 1'b0;
        do_swap();
        check("swap2_wr_bank", 64'(wr_bank), 64'h0);
        read_req_wght = 1'b1; r_addr_wght = 10'd9;
        step();
        read_req_wght = 1'b0;
        check("wght_rdata", 64'(r_data_wght), 64'h1234);
        check("wght_rvalid", 64'(r_valid_wght), 64'h1);

        // write in the swap cycle still targets the pre-swap bank
        write_en_iact = 1'b1; w_addr_iact = 10'd6; w_data_iact = 16'h0066; swap = 1'b1;
        step();
        write_en_iact = 1'b0; swap = 1'b0;
        check("swap3_wr_bank", 64'(wr_bank), 64'h1);
        iact_rd(10'd6);
        check("iact_swap_cycle_wr", 64'(r_data_iact), 64'h0066);

        // psum read-first on same-cycle write
        psum_wr(10'd8, 16'h0055);
        write_en_psum = 1'b1; acc_en_psum = 1'b0; w_addr_psum = 10'd8; w_data_psum = 16'h0077;
        read_req_psum = 1'b1; r_addr_psum = 10'd8;
        step();
        write_en_psum = 1'b0; read_req_psum = 1'b0;
        check("psum_read_first", 64'(r_data_psum), 64'h0055);
        check("psum_rvalid", 64'(r_valid_psum), 64'h1);
        psum_rd(10'd8);
        check("psum_overwrite", 64'(r_data_psum), 64'h0077);

        // back-to-back accumulate: 0x10 + 3 + 3
        psum_wr(10'd7, 16'h0010);
        write_en_psum = 1'b1; acc_en_psum = 1'b1; w_addr_psum = 10'd7; w_data_psum = 16'h0003;
        step();
        step();
        write_en_psum = 1'b0; acc_en_psum = 1'b0;
        step();
        psum_rd(10'd7);
        check("psum_acc_b2b", 64'(r_data_psum), 64'h0016);

        // accumulate wraps mod 2^16
        psum_wr(10'h3FF, 16'hFFFF);
        write_en_psum = 1'b1; acc_en_psum = 1'b1; w_addr_psum = 10'h3FF; w_data_psum = 16'h0002;
        step();
        write_en_psum = 1'b0; acc_en_psum = 1'b0;
        step();
        psum_rd(10'h3FF);
        check("psum_acc_wrap", 64'(r_data_psum), 64'h0001);

        // inter burst with address wrap and an ignored second request
        psum_wr(10'd1022, 16'h0001);
        psum_wr(10'd1023, 16'h0002);
        psum_wr(10'd0, 16'h0003);
        read_req_psum_inter = 1'b1; r_addr_psum_inter = 10'd1022;
        step();
        read_req_psum_inter = 1'b0;
        check("inter_busy_t1", 64'(busy_psum_inter), 64'h1);
        check("inter_no_pulse_t1", 64'(read_en_psum_inter), 64'h0);
        step();
        read_req_psum_inter = 1'b1; r_addr_psum_inter = 10'd5;
        step();
        read_req_psum_inter = 1'b0;
        check("inter_no_pulse_t3", 64'(read_en_psum_inter), 64'h0);
        step();
        check("inter_pulse_t4", 64'(read_en_psum_inter), 64'h1);
        check("inter_data_t4", 64'(r_data_psum_inter), 64'h0003_0002_0001);
        check("inter_busy_t4", 64'(busy_psum_inter), 64'h1);
        step();
        check("inter_pulse_end", 64'(read_en_psum_inter), 64'h0);
        check("inter_idle", 64'(busy_psum_inter), 64'h0);
        check("inter_data_hold", 64'(r_data_psum_inter), 64'h0003_0002_0001);
        step();
        check("inter_ignored_req", 64'(read_en_psum_inter), 64'h0);

        // fetch sees writes landing on its own fetch edge (overwrite and accumulate commit)
        read_req_psum_inter = 1'b1; r_addr_psum_inter = 10'd1022;
        step();
        read_req_psum_inter = 1'b0;
        write_en_psum = 1'b1; acc_en_psum = 1'b0; w_addr_psum = 10'd1022; w_data_psum = 16'h000A;
        step();
        acc_en_psum = 1'b1; w_addr_psum = 10'd0; w_data_psum = 16'h0004;
        step();
        write_en_psum = 1'b0; acc_en_psum = 1'b0;
        step();
        check("inter_bypass_pulse", 64'(read_en_psum_inter), 64'h1);
        check("inter_bypass_data", 64'(r_data_psum_inter), 64'h0007_0002_000A);
        step();

        // reset mid-fetch with an accumulate still in flight
        psum_wr(10'd20, 16'hBEEF);
        psum_wr(10'd30, 16'h0005);
        read_req_psum_inter = 1'b1; r_addr_psum_inter = 10'd20;
        step();
        read_req_psum_inter = 1'b0;
        check("abort_busy_before", 64'(busy_psum_inter), 64'h1);
        write_en_psum = 1'b1; acc_en_psum = 1'b1; w_addr_psum = 10'd30; w_data_psum = 16'h0001;
        step();
        write_en_psum = 1'b0; acc_en_psum = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_busy_now", 64'(busy_psum_inter), 64'h0);
        check("abort_read_en", 64'(read_en_psum_inter), 64'h0);
        check("abort_inter_data", 64'(r_data_psum_inter), 64'h0);
        check("abort_wr_bank", 64'(wr_bank), 64'h0);
        check("abort_rdata_psum", 64'(r_data_psum), 64'h0);
        check("abort_rdata_iact", 64'(r_data_iact), 64'h0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_pulse", 64'(read_en_psum_inter), 64'h0);
        end
        psum_rd(10'd30);
        check("abort_acc_dropped", 64'(r_data_psum), 64'h0005);
        psum_rd(10'd20);
        check("mem_kept_psum", 64'(r_data_psum), 64'hBEEF);
        read_req_wght = 1'b1; r_addr_wght = 10'd9;
        step();
        read_req_wght = 1'b0;
        check("mem_kept_wght", 64'(r_data_wght), 64'h1234);

        // three-bank rotation
        iact_wr(10'd40, 16'h00B0);
        do_swap3();
        check("nb3_wr_bank_1", 64'(wr_bank3), 64'h1);
        iact_wr(10'd40, 16'h00B1);
        do_swap3();
        check("nb3_wr_bank_2", 64'(wr_bank3), 64'h2);
        iact_rd(10'd40);
        check("nb3_rd_bank0", 64'(r_data_iact3), 64'h00B0);
        iact_wr(10'd40, 16'h00B2);
        do_swap3();
        check("nb3_wr_bank_0", 64'(wr_bank3), 64'h0);
        iact_rd(10'd40);
        check("nb3_rd_bank1", 64'(r_data_iact3), 64'h00B1);
        do_swap3();
        iact_rd(10'd40);
        check("nb3_rd_bank2", 64'(r_data_iact3), 64'h00B2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_cluster_pp.md
GB_CLUSTER_PP -- requirements
Module: gb_cluster_pp

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16, word width of every buffer.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 10; each bank holds 2^ADDR_BITWIDTH words.
REQ-003 SHALL have parameter X_dim, default 3, words per inter-PE psum burst (>=1).
REQ-004 SHALL have parameter NUM_BANKS, default 2, ping-pong banks per iact/wght buffer (>=2).
REQ-005 SHALL have ports, in order: clk in 1, single clock; reset in 1, asynchronous active-low reset.
REQ-006 SHALL have, for T in {iact, wght}: read_req_T in 1; r_addr_T in ADDR_BITWIDTH; r_data_T out DATA_BITWIDTH; r_valid_T out 1; write_en_T in 1; w_addr_T in ADDR_BITWIDTH; w_data_T in DATA_BITWIDTH.
REQ-007 SHALL have psum ports: read_req_psum in 1; r_addr_psum in ADDR_BITWIDTH; r_data_psum out DATA_BITWIDTH; r_valid_psum out 1; write_en_psum in 1; acc_en_psum in 1, accumulate instead of overwrite; w_addr_psum in ADDR_BITWIDTH; w_data_psum in DATA_BITWIDTH.
REQ-008 SHALL have inter ports: read_req_psum_inter in 1; r_addr_psum_inter in ADDR_BITWIDTH; r_data_psum_inter out DATA_BITWIDTH*X_dim; read_en_psum_inter out 1, burst-done pulse; busy_psum_inter out 1.
REQ-009 SHALL have swap in 1, advances iact/wght bank pointers; wr_bank out clog2(NUM_BANKS), current fill bank.

Function
REQ-010 iact and wght SHALL each hold NUM_BANKS banks; writes go to bank wr_bank, reads come from bank rd_bank = (wr_bank+1) mod NUM_BANKS.
REQ-011 swap high at edge t SHALL increment wr_bank mod NUM_BANKS from t+1; reads/writes in cycle t use pre-swap banks.
REQ-012 Regular reads (iact, wght, psum) SHALL have 1-cycle latency: read_req at t -> r_data valid and r_valid=1 in t+1; r_valid=0 otherwise, r_data holds last value.
REQ-013 Read and write of same psum address in one cycle SHALL return pre-write data (read-first).
REQ-014 write_en_psum with acc_en_psum=0 SHALL store w_data_psum at t+1.
REQ-015 write_en_psum with acc_en_psum=1 at t SHALL commit mem[a]+w_data_psum at edge t+1 (2-stage read-modify-write), sum truncated mod 2^DATA_BITWIDTH.
REQ-016 Back-to-back accumulates to the same address SHALL forward the pending sum, never lose an update.
REQ-017 Inter engine FSM SHALL have states IDLE, FETCH, DONE.
REQ-018 IDLE + read_req_psum_inter at t SHALL latch address A, enter FETCH; busy_psum_inter=1 from t+1 through DONE.
REQ-019 FETCH SHALL last X_dim cycles, word k from address (A+k) mod 2^ADDR_BITWIDTH into bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
REQ-020 DONE SHALL be 1 cycle at t+X_dim+1 with read_en_psum_inter=1, then IDLE; r_data_psum_inter holds until next DONE.
REQ-021 read_req_psum_inter while busy SHALL be ignored (no queueing).
REQ-022 FETCH SHALL see psum writes committed at or before that word's fetch edge.

Reset
REQ-023 reset low SHALL immediately force: all r_data* =0, r_valid*=0, read_en_psum_inter=0, busy_psum_inter=0, FSM=IDLE, wr_bank=0, RMW pipeline cleared.
REQ-024 Memory contents SHALL NOT be reset; reset mid-FETCH aborts without DONE pulse; pending accumulate is dropped.

Verification
REQ-025 Write iact bank0 addr5=0x00AA, swap, read addr5 -> r_data_iact=0x00AA, r_valid_iact=1 one cycle after request; wr_bank=1.
REQ-026 psum addr7=0x0010; accumulate 0x0003 twice back-to-back -> read addr7 returns 0x0016.
REQ-027 psum addr 0x3FF=0xFFFF, accumulate 0x0002 -> reads 0x0001 (wrap).
REQ-028 psum 1022,1023,0 = 1,2,3; inter request A=1022, X_dim=3 -> read_en_psum_inter pulse at t+4, r_data_psum_inter=0x0003_0002_0001; second request at t+2 ignored.
REQ-029 reset low during FETCH -> busy_psum_inter=0 immediately, no pulse; memory data intact after reset.
REQ-030 NUM_BANKS=3: three swaps -> wr_bank 1,2,0; reads always from (wr_bank+1) mod 3.
